tcdm2axi_lite_bridge: RTL and testbench
=======================================

TCDM2AXI_LITE_BRIDGE -- requirements
Module: tcdm2axi_lite_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width on both sides.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width on both sides; BE width is DATA_WIDTH/8.
REQ-003 SHALL have port clk_i  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, synchronous and active-low.
REQ-005 SHALL have TCDM slave inputs: tcdm_req_i 1, tcdm_add_i ADDR_WIDTH, tcdm_wen_i 1 (0=write, 1=read), tcdm_wdata_i DATA_WIDTH, tcdm_be_i DATA_WIDTH/8.
REQ-006 SHALL have TCDM slave outputs: tcdm_gnt_o 1, tcdm_r_valid_o 1, tcdm_r_rdata_o DATA_WIDTH, tcdm_r_opc_o 1 (error flag).
REQ-007 SHALL have AXI-Lite AW channel: aw_addr_o out ADDR_WIDTH, aw_prot_o out 3, aw_valid_o out 1, aw_ready_i in 1.
REQ-008 SHALL have AXI-Lite W channel: w_data_o out DATA_WIDTH, w_strb_o out DATA_WIDTH/8, w_valid_o out 1, w_ready_i in 1.
REQ-009 SHALL have AXI-Lite B channel: b_resp_i in 2, b_valid_i in 1, b_ready_o out 1.
REQ-010 SHALL have AXI-Lite AR channel: ar_addr_o out ADDR_WIDTH, ar_prot_o out 3, ar_valid_o out 1, ar_ready_i in 1.
REQ-011 SHALL have AXI-Lite R channel: r_data_i in DATA_WIDTH, r_resp_i in 2, r_valid_i in 1, r_ready_o out 1.
REQ-012 SHALL have err_clr_i  input  1  clears error counter; err_cnt_o  output  16  saturating error count.

Function
REQ-013 SHALL implement FSM states IDLE, WR, WR_RESP, RD, RD_RESP; exactly one TCDM transaction outstanding.
REQ-014 tcdm_gnt_o SHALL equal tcdm_req_i AND (state==IDLE), combinationally.
REQ-015 On req&gnt SHALL register add, wdata, be; next state WR if wen=0, else RD.
REQ-016 In WR, aw_valid_o and w_valid_o SHALL both be asserted from the first WR cycle; each deasserts independently after its own valid&ready cycle.
REQ-017 WR SHALL move to WR_RESP the cycle after the later of the two handshakes; same-cycle AW and W handshakes are legal.
REQ-018 In RD, ar_valid_o SHALL be held high until ar_ready_i; then move to RD_RESP.
REQ-019 b_ready_o SHALL be 1 only in WR_RESP; r_ready_o SHALL be 1 only in RD_RESP.
REQ-020 On B or R handshake SHALL return to IDLE and assert tcdm_r_valid_o for exactly one cycle in the next cycle.
REQ-021 tcdm_r_rdata_o SHALL be r_data_i captured on R handshake, 0 for writes, and held until the next response.
REQ-022 Addresses SHALL pass unmodified (including [1:0]); w_strb_o = registered be; aw_prot_o = ar_prot_o = 3'b000.
REQ-023 be=0 writes SHALL still be issued on AXI with w_strb_o=0.
REQ-024 Once asserted, any AXI valid and its payload SHALL be stable until its ready.
REQ-025 Minimum latency: gnt cycle 0, AXI valid cycle 1, tcdm_r_valid_o cycle 3 with zero-wait slave; a new gnt SHALL be possible in the tcdm_r_valid_o cycle.

Reset
REQ-026 While rst_ni=0 at a clock edge: state=IDLE; aw/w/ar_valid_o, b/r_ready_o, tcdm_r_valid_o, tcdm_r_opc_o = 0; tcdm_r_rdata_o=0; err_cnt_o=0.
REQ-027 Reset mid-transaction SHALL abandon it with no tcdm_r_valid_o; the AXI slave is reset by the same rst_ni.

Configuration
REQ-028 Macro TCDM2AXIL_ERR_REPORT_EN defined: tcdm_r_opc_o = (resp[1]==1) for the completing response; err_cnt_o increments per such response, saturates at 16'hFFFF, cleared by err_clr_i (clear wins over increment).
REQ-029 Macro undefined: tcdm_r_opc_o and err_cnt_o tied to 0; err_clr_i ignored; no counter logic.

Verification
REQ-030 Read 0x1A10_0004, slave ready same cycle, r_data=0xDEADBEEF, OKAY -> tcdm_r_valid_o in cycle 3, rdata 0xDEADBEEF, opc 0.
REQ-031 Write 0x1C00_0010 data 0x12345678 be 4'b0011, aw_ready 3 cycles before w_ready -> AW and W each accepted once, strb 0011, one tcdm_r_valid_o after B.
REQ-032 Back-to-back req held high for 4 transactions -> exactly 4 gnt, never gnt while busy, 4 tcdm_r_valid_o in order.
REQ-033 ERR_REPORT_EN defined, 3 reads with SLVERR then err_clr_i with concurrent DECERR -> opc=1 each, err_cnt_o 3 then 0.
REQ-034 rst_ni low during WR_RESP -> all valids/readys 0 next cycle, no tcdm_r_valid_o, next req granted immediately.

Source files
------------

// File: rtl/tcdm2axi_lite_bridge.sv
// TCDM slave to AXI-Lite master bridge, one transaction outstanding at a time.
// Optional error reporting (tcdm_r_opc_o, err_cnt_o) enabled by TCDM2AXIL_ERR_REPORT_EN.
//
// state   | meaning
// IDLE    | grant any TCDM request, capture address/data/strobe
// WR      | AW and W valid, each dropped after its own handshake
// WR_RESP | waiting for B
// RD      | AR valid until accepted
// RD_RESP | waiting for R
module tcdm2axi_lite_bridge #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    tcdm_req_i,
    input  logic [ADDR_WIDTH-1:0]   tcdm_add_i,
    input  logic                    tcdm_wen_i,
    input  logic [DATA_WIDTH-1:0]   tcdm_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] tcdm_be_i,
    output logic                    tcdm_gnt_o,
    output logic                    tcdm_r_valid_o,
    output logic [DATA_WIDTH-1:0]   tcdm_r_rdata_o,
    output logic                    tcdm_r_opc_o,
    output logic [ADDR_WIDTH-1:0]   aw_addr_o,
    output logic [2:0]              aw_prot_o,
    output logic                    aw_valid_o,
    input  logic                    aw_ready_i,
    output logic [DATA_WIDTH-1:0]   w_data_o,
    output logic [DATA_WIDTH/8-1:0] w_strb_o,
    output logic                    w_valid_o,
    input  logic                    w_ready_i,
    input  logic [1:0]              b_resp_i,
    input  logic                    b_valid_i,
    output logic                    b_ready_o,
    output logic [ADDR_WIDTH-1:0]   ar_addr_o,
    output logic [2:0]              ar_prot_o,
    output logic                    ar_valid_o,
    input  logic                    ar_ready_i,
    input  logic [DATA_WIDTH-1:0]   r_data_i,
    input  logic [1:0]              r_resp_i,
    input  logic                    r_valid_i,
    output logic                    r_ready_o,
    input  logic                    err_clr_i,
    output logic [15:0]             err_cnt_o
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD,
        RD_RESP
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [BE_WIDTH-1:0]     be_q, be_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

    logic aw_hs, w_hs, ar_hs, b_hs, r_hs;

    assign tcdm_gnt_o = tcdm_req_i & (state_q == IDLE);

    assign aw_valid_o = (state_q == WR) & ~aw_done_q;
    assign w_valid_o  = (state_q == WR) & ~w_done_q;
    assign ar_valid_o = (state_q == RD);
    assign b_ready_o  = (state_q == WR_RESP);
    assign r_ready_o  = (state_q == RD_RESP);

    assign aw_addr_o = addr_q;
    assign ar_addr_o = addr_q;
    assign aw_prot_o = 3'b000;
    assign ar_prot_o = 3'b000;
    assign w_data_o  = wdata_q;
    assign w_strb_o  = be_q;

    assign aw_hs = aw_valid_o & aw_ready_i;
    assign w_hs  = w_valid_o & w_ready_i;
    assign ar_hs = ar_valid_o & ar_ready_i;
    assign b_hs  = b_valid_i & b_ready_o;
    assign r_hs  = r_valid_i & r_ready_o;

    assign tcdm_r_valid_o = rsp_valid_q;
    assign tcdm_r_rdata_o = rdata_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        rsp_valid_d = 1'b0;
        rdata_d     = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (tcdm_gnt_o) begin
                    addr_d  = tcdm_add_i;
                    wdata_d = tcdm_wdata_i;
                    be_d    = tcdm_be_i;
                    state_d = tcdm_wen_i ? RD : WR;
                end
            end
            WR: begin
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                // Both channels done: leave WR and rearm the done flags for the next write.
                if (aw_done_d && w_done_d) begin
                    state_d   = WR_RESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            WR_RESP: begin
                if (b_hs) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rdata_d     = '0;
                end
            end
            RD: begin
                if (ar_hs) begin
                    state_d = RD_RESP;
                end
            end
            RD_RESP: begin
                if (r_hs) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rdata_d     = r_data_i;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
        end
    end

`ifdef TCDM2AXIL_ERR_REPORT_EN
    logic        opc_q, opc_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic        rsp_err;
    logic        unused_resp_lsb;

    // SLVERR and DECERR both have resp[1] set; resp[0] carries no extra meaning here.
    assign unused_resp_lsb = ^{b_resp_i[0], r_resp_i[0]};

    always_comb begin
        rsp_err   = (b_hs & b_resp_i[1]) | (r_hs & r_resp_i[1]);
        opc_d     = opc_q;
        err_cnt_d = err_cnt_q;
        if (b_hs) begin
            opc_d = b_resp_i[1];
        end else if (r_hs) begin
            opc_d = r_resp_i[1];
        end
        if (err_clr_i) begin
            err_cnt_d = '0;
        end else if (rsp_err && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            opc_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            opc_q     <= opc_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign tcdm_r_opc_o = opc_q;
    assign err_cnt_o    = err_cnt_q;
`else
    logic unused_err_inputs;

    assign unused_err_inputs = ^{err_clr_i, b_resp_i, r_resp_i};
    assign tcdm_r_opc_o      = 1'b0;
    assign err_cnt_o         = '0;
`endif

endmodule

// File: tb/tb_tcdm2axi_lite_bridge.sv
// Scoreboard bench for tcdm2axi_lite_bridge: directed TCDM transactions against an AXI-Lite slave model.
module tb_tcdm2axi_lite_bridge;

`ifdef TCDM2AXIL_ERR_REPORT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        tcdm_req_i = 1'b0;
    logic [31:0] tcdm_add_i = '0;
    logic        tcdm_wen_i = 1'b0;
    logic [31:0] tcdm_wdata_i = '0;
    logic [3:0]  tcdm_be_i = '0;
    logic        tcdm_gnt_o, tcdm_r_valid_o, tcdm_r_opc_o;
    logic [31:0] tcdm_r_rdata_o;
    logic [31:0] aw_addr_o, ar_addr_o, w_data_o;
    logic [2:0]  aw_prot_o, ar_prot_o;
    logic [3:0]  w_strb_o;
    logic        aw_valid_o, w_valid_o, ar_valid_o, b_ready_o, r_ready_o;
    logic        aw_ready_i = 1'b0, w_ready_i = 1'b0, ar_ready_i = 1'b0;
    logic        b_valid_i = 1'b0, r_valid_i = 1'b0;
    logic [1:0]  b_resp_i = '0, r_resp_i = '0;
    logic [31:0] r_data_i = '0;
    logic        err_clr_i = 1'b0;
    logic [15:0] err_cnt_o;

    tcdm2axi_lite_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .tcdm_req_i(tcdm_req_i), .tcdm_add_i(tcdm_add_i), .tcdm_wen_i(tcdm_wen_i),
        .tcdm_wdata_i(tcdm_wdata_i), .tcdm_be_i(tcdm_be_i),
        .tcdm_gnt_o(tcdm_gnt_o), .tcdm_r_valid_o(tcdm_r_valid_o),
        .tcdm_r_rdata_o(tcdm_r_rdata_o), .tcdm_r_opc_o(tcdm_r_opc_o),
        .aw_addr_o(aw_addr_o), .aw_prot_o(aw_prot_o), .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
        .w_data_o(w_data_o), .w_strb_o(w_strb_o), .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
        .b_resp_i(b_resp_i), .b_valid_i(b_valid_i), .b_ready_o(b_ready_o),
        .ar_addr_o(ar_addr_o), .ar_prot_o(ar_prot_o), .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
        .r_data_i(r_data_i), .r_resp_i(r_resp_i), .r_valid_i(r_valid_i), .r_ready_o(r_ready_o),
        .err_clr_i(err_clr_i), .err_cnt_o(err_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        opc;
        int          exp_cyc;
    } rsp_t;

    rsp_t        exp_q[$];
    logic [31:0] aw_q[$];
    logic [35:0] w_q[$];
    logic [31:0] ar_q[$];
    logic [1:0]  b_q[$];
    logic [33:0] r_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int outstanding = 0;
    int rv_cnt = 0, gnt_cnt = 0, aw_hs_cnt = 0, w_hs_cnt = 0, ar_hs_cnt = 0;
    int aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
    int aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
    bit aw_done = 0, w_done = 0, ar_done = 0, b_done = 0, r_done = 0;
    bit aw_log = 0, w_log = 0, b_pend = 0, r_pend = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h @%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor and AXI-Lite slave model; handshakes are decided at the negedge before the edge that takes them.
    always @(negedge clk) begin
        if (!rst_ni) begin
            exp_q.delete(); aw_q.delete(); w_q.delete(); ar_q.delete(); b_q.delete(); r_q.delete();
            outstanding = 0;
            aw_ready_i = 0; w_ready_i = 0; ar_ready_i = 0; b_valid_i = 0; r_valid_i = 0;
            aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
            aw_done = 0; w_done = 0; ar_done = 0; b_done = 0; r_done = 0;
            aw_log = 0; w_log = 0; b_pend = 0; r_pend = 0;
        end else begin
            if (tcdm_r_valid_o) begin
                rv_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_r_valid", tcdm_r_valid_o, 1'b0);
                end else begin
                    rsp_t e;
                    e = exp_q.pop_front();
                    check("rsp_rdata", tcdm_r_rdata_o, e.rdata);
                    check("rsp_opc", tcdm_r_opc_o, e.opc);
                    if (e.exp_cyc >= 0) check("rsp_latency", cyc, e.exp_cyc);
                end
                if (outstanding > 0) outstanding--;
            end
            check("gnt", tcdm_gnt_o, tcdm_req_i && (outstanding == 0));
            if (tcdm_gnt_o) begin
                outstanding++;
                gnt_cnt++;
            end

            if (b_done) begin
                b_valid_i = 0; b_done = 0;
            end else if (b_valid_i) begin
                if (b_ready_o) b_done = 1;
            end else if (b_pend) begin
                if (b_wait >= b_delay) begin
                    b_valid_i = 1;
                    b_resp_i  = (b_q.size() != 0) ? b_q.pop_front() : 2'b00;
                    b_pend = 0; b_wait = 0;
                    if (b_ready_o) b_done = 1;
                end else b_wait++;
            end

            if (r_done) begin
                r_valid_i = 0; r_done = 0;
            end else if (r_valid_i) begin
                if (r_ready_o) r_done = 1;
            end else if (r_pend) begin
                if (r_wait >= r_delay) begin
                    logic [33:0] rr;
                    rr = (r_q.size() != 0) ? r_q.pop_front() : 34'h0;
                    r_valid_i = 1; r_data_i = rr[33:2]; r_resp_i = rr[1:0];
                    r_pend = 0; r_wait = 0;
                    if (r_ready_o) r_done = 1;
                end else r_wait++;
            end

            if (aw_done) begin
                check("aw_valid_after_hs", aw_valid_o, 1'b0);
                aw_ready_i = 0; aw_done = 0;
            end else if (aw_valid_o) begin
                if (aw_q.size() == 0) check("aw_unexpected", aw_valid_o, 1'b0);
                else begin
                    check("aw_addr", aw_addr_o, aw_q[0]);
                    check("aw_prot", aw_prot_o, 3'b000);
                    if (aw_wait >= aw_delay) begin
                        aw_ready_i = 1; aw_done = 1; aw_log = 1; aw_hs_cnt++; aw_wait = 0;
                        void'(aw_q.pop_front());
                    end else aw_wait++;
                end
            end else if (aw_wait != 0) begin
                check("aw_valid_held", aw_valid_o, 1'b1);
                aw_wait = 0;
            end

            if (w_done) begin
                check("w_valid_after_hs", w_valid_o, 1'b0);
                w_ready_i = 0; w_done = 0;
            end else if (w_valid_o) begin
                if (w_q.size() == 0) check("w_unexpected", w_valid_o, 1'b0);
                else begin
                    check("w_data", w_data_o, w_q[0][35:4]);
                    check("w_strb", w_strb_o, w_q[0][3:0]);
                    if (w_wait >= w_delay) begin
                        w_ready_i = 1; w_done = 1; w_log = 1; w_hs_cnt++; w_wait = 0;
                        void'(w_q.pop_front());
                    end else w_wait++;
                end
            end else if (w_wait != 0) begin
                check("w_valid_held", w_valid_o, 1'b1);
                w_wait = 0;
            end

            if (aw_log && w_log) begin
                aw_log = 0; w_log = 0; b_pend = 1; b_wait = 0;
            end

            if (ar_done) begin
                check("ar_valid_after_hs", ar_valid_o, 1'b0);
                ar_ready_i = 0; ar_done = 0;
            end else if (ar_valid_o) begin
                if (ar_q.size() == 0) check("ar_unexpected", ar_valid_o, 1'b0);
                else begin
                    check("ar_addr", ar_addr_o, ar_q[0]);
                    check("ar_prot", ar_prot_o, 3'b000);
                    if (ar_wait >= ar_delay) begin
                        ar_ready_i = 1; ar_done = 1; ar_hs_cnt++; ar_wait = 0;
                        r_pend = 1; r_wait = 0;
                        void'(ar_q.pop_front());
                    end else ar_wait++;
                end
            end else if (ar_wait != 0) begin
                check("ar_valid_held", ar_valid_o, 1'b1);
                ar_wait = 0;
            end
        end
    end

    // Starts and ends at posedge+1; with hold set, req stays high for a back-to-back follow-up.
    task automatic txn(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] rdata, input logic [1:0] resp,
                       input bit lat, input bit hold);
        int n;
        rsp_t e;
        n = 0;
        tcdm_req_i = 1; tcdm_wen_i = wen; tcdm_add_i = addr; tcdm_wdata_i = wdata; tcdm_be_i = be;
        @(negedge clk);
        while (!tcdm_gnt_o && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!tcdm_gnt_o) begin
            check("gnt_timeout", tcdm_gnt_o, 1'b1);
        end else begin
            e.rdata   = wen ? rdata : 32'h0;
            e.opc     = ERR_EN & resp[1];
            e.exp_cyc = lat ? cyc + 3 : -1;
            exp_q.push_back(e);
            if (!wen) begin
                aw_q.push_back(addr);
                w_q.push_back({wdata, be});
                b_q.push_back(resp);
            end else begin
                ar_q.push_back(addr);
                r_q.push_back({rdata, resp});
            end
        end
        @(posedge clk); #1;
        if (!hold) tcdm_req_i = 0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            n++;
            @(negedge clk);
        end
        check("idle_timeout", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rv0, g0, aw0, w0, ar0, n;

        repeat (3) @(posedge clk);
        #1;
        check("rst_aw_valid", aw_valid_o, 1'b0);
        check("rst_w_valid", w_valid_o, 1'b0);
        check("rst_ar_valid", ar_valid_o, 1'b0);
        check("rst_b_ready", b_ready_o, 1'b0);
        check("rst_r_ready", r_ready_o, 1'b0);
        check("rst_r_valid", tcdm_r_valid_o, 1'b0);
        check("rst_rdata", tcdm_r_rdata_o, 32'h0);
        check("rst_opc", tcdm_r_opc_o, 1'b0);
        check("rst_err_cnt", err_cnt_o, 16'h0);
        rst_ni = 1;
        @(posedge clk); #1;

        // zero-wait read, response expected in cycle 3
        txn(1'b1, 32'h1A10_0004, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b00, 1'b1, 1'b0);
        wait_idle();

        // AW accepted three cycles before W
        w_delay = 3;
        rv0 = rv_cnt; aw0 = aw_hs_cnt; w0 = w_hs_cnt;
        txn(1'b0, 32'h1C00_0010, 32'h1234_5678, 4'b0011, 32'h0, 2'b00, 1'b0, 1'b0);
        wait_idle();
        check("wr_aw_once", aw_hs_cnt - aw0, 1);
        check("wr_w_once", w_hs_cnt - w0, 1);
        check("wr_one_rsp", rv_cnt - rv0, 1);
        w_delay = 0;

        // four back-to-back transactions with req held high
        rv0 = rv_cnt; g0 = gnt_cnt;
        txn(1'b1, 32'h0000_0003, 32'h0, 4'h0, 32'hCAFE_0001, 2'b00, 1'b1, 1'b1);
        txn(1'b0, 32'h2000_0008, 32'hAABB_CCDD, 4'b0000, 32'h0, 2'b00, 1'b1, 1'b1);
        txn(1'b1, 32'h3000_0101, 32'h0, 4'h0, 32'h0BAD_F00D, 2'b00, 1'b1, 1'b1);
        txn(1'b0, 32'h3000_0200, 32'h8765_4321, 4'b1111, 32'h0, 2'b00, 1'b1, 1'b0);
        wait_idle();
        check("b2b_rsp_count", rv_cnt - rv0, 4);
        check("b2b_gnt_count", gnt_cnt - g0, 4);

        // slow slave on every read channel
        ar_delay = 2; r_delay = 3;
        ar0 = ar_hs_cnt;
        txn(1'b1, 32'h4000_0002, 32'h0, 4'h0, 32'h55AA_55AA, 2'b00, 1'b0, 1'b0);
        wait_idle();
        check("slow_rd_ar_once", ar_hs_cnt - ar0, 1);
        ar_delay = 0; r_delay = 0; aw_delay = 2; b_delay = 2;
        txn(1'b0, 32'h4000_0010, 32'h0F0F_0F0F, 4'b0100, 32'h0, 2'b00, 1'b0, 1'b0);
        wait_idle();
        aw_delay = 0; b_delay = 0;

        // error responses, then clear concurrent with a DECERR
        txn(1'b1, 32'h5000_0000, 32'h0, 4'h0, 32'h0000_0001, 2'b10, 1'b1, 1'b0);
        txn(1'b1, 32'h5000_0004, 32'h0, 4'h0, 32'h0000_0002, 2'b10, 1'b1, 1'b0);
        txn(1'b1, 32'h5000_0008, 32'h0, 4'h0, 32'h0000_0003, 2'b10, 1'b1, 1'b0);
        wait_idle();
        check("err_cnt_after_3", err_cnt_o, ERR_EN ? 16'd3 : 16'd0);
        err_clr_i = 1;
        txn(1'b1, 32'h5000_000C, 32'h0, 4'h0, 32'h0000_0004, 2'b11, 1'b1, 1'b0);
        wait_idle();
        err_clr_i = 0;
        check("err_cnt_after_clr", err_cnt_o, 16'd0);
        txn(1'b0, 32'h5000_0010, 32'hFFFF_0000, 4'b1000, 32'h0, 2'b10, 1'b1, 1'b0);
        wait_idle();
        check("err_cnt_after_wr_err", err_cnt_o, ERR_EN ? 16'd1 : 16'd0);

        // reset while waiting for B abandons the write
        b_delay = 1000;
        rv0 = rv_cnt;
        txn(1'b0, 32'h6000_0000, 32'h1111_2222, 4'b1111, 32'h0, 2'b00, 1'b0, 1'b0);
        n = 0;
        while (!b_ready_o && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("reach_wr_resp", b_ready_o, 1'b1);
        @(posedge clk); #1;
        rst_ni = 0;
        @(posedge clk); #1;
        rst_ni = 1;
        b_delay = 0;
        check("rst_mid_aw_valid", aw_valid_o, 1'b0);
        check("rst_mid_w_valid", w_valid_o, 1'b0);
        check("rst_mid_ar_valid", ar_valid_o, 1'b0);
        check("rst_mid_b_ready", b_ready_o, 1'b0);
        check("rst_mid_r_ready", r_ready_o, 1'b0);
        check("rst_mid_r_valid", tcdm_r_valid_o, 1'b0);
        tcdm_req_i = 1; tcdm_wen_i = 1; tcdm_add_i = 32'h7000_0000;
        #1;
        check("gnt_after_rst", tcdm_gnt_o, 1'b1);
        txn(1'b1, 32'h7000_0000, 32'h0, 4'h0, 32'h7777_0000, 2'b00, 1'b1, 1'b0);
        wait_idle();
        check("rst_only_new_rsp", rv_cnt - rv0, 1);

        repeat (3) @(posedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
